crc_frame_rx: RTL and testbench

//  Receive-side deframer and CRC-4 checker for the 16-symbol CRC frame. Samples the

---
 rtl/crc_frame_rx.sv | 122 ++++++++++++
 tb/tb_crc_frame_rx.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/crc_frame_rx.sv
// Receive-side deframer for the 16-symbol CRC-4 frame: samples in_bit once per symbol,
// rebuilds the codeword, checks x^4+x+1 serially and keeps saturating frame statistics.
module crc_frame_rx #(
    parameter int SAMPLE_PHASE = 128,
    parameter int CNT_W        = 8
) (
    input  logic             clk_sys,
    input  logic             rst_n,
    input  logic             en,
    input  logic [7:0]       phase,
    input  logic [3:0]       sign_cnt,
    input  logic             in_bit,
    output logic [15:0]      code_out,
    output logic [11:0]      data_out,
    output logic             crc_ok,
    output logic             frame_valid,
    output logic             sync_err,
    output logic [CNT_W-1:0] frame_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output logic [1:0]       state_dbg
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RECV  = 2'd1,
        CHECK = 2'd2
    } state_t;

    localparam logic [7:0] SAMPLE_PHASE_L = SAMPLE_PHASE[7:0];

    state_t      state;
    logic [15:0] shreg;
    logic [3:0]  lfsr;
    logic [3:0]  bit_idx;
    logic        samp;

    // No valid/ready handshake here: frame_valid and sync_err are single-cycle
    // strobes with no back-pressure; code_out/data_out/crc_ok hold until the next CHECK.
    assign samp      = en && (phase == SAMPLE_PHASE_L);
    assign data_out  = code_out[11:0];
    assign state_dbg = state;

    function automatic logic [3:0] lfsr_step(input logic [3:0] r, input logic b);
        logic fb;
        fb = r[3] ^ b;
        return {r[2:0], 1'b0} ^ (fb ? 4'b0011 : 4'b0000);
    endfunction

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            shreg       <= 16'h0000;
            lfsr        <= 4'd0;
            bit_idx     <= 4'd0;
            code_out    <= 16'h0000;
            crc_ok      <= 1'b0;
            frame_valid <= 1'b0;
            sync_err    <= 1'b0;
            frame_cnt   <= '0;
            err_cnt     <= '0;
        end else begin
            frame_valid <= 1'b0;
            sync_err    <= 1'b0;
            if (!en) begin
                // Abort: partial frame is dropped silently, last results are kept.
                state <= IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        if (samp && sign_cnt == 4'd0) begin
                            shreg   <= {15'h0000, in_bit};
                            lfsr    <= lfsr_step(4'd0, in_bit);
                            bit_idx <= 4'd1;
                            state   <= RECV;
                        end
                    end
                    RECV: begin
                        if (samp) begin
                            if (sign_cnt == bit_idx) begin
                                shreg[bit_idx] <= in_bit;
                                lfsr           <= lfsr_step(lfsr, in_bit);
                                if (bit_idx == 4'd15) begin
                                    state <= CHECK;
                                end else begin
                                    bit_idx <= bit_idx + 4'd1;
                                end
                            end else begin
                                sync_err <= 1'b1;
                                if (err_cnt != {CNT_W{1'b1}}) begin
                                    err_cnt <= err_cnt + 1'b1;
                                end
                                // A broken sequence landing on symbol 0 is a new frame start.
                                if (sign_cnt == 4'd0) begin
                                    shreg   <= {15'h0000, in_bit};
                                    lfsr    <= lfsr_step(4'd0, in_bit);
                                    bit_idx <= 4'd1;
                                    state   <= RECV;
                                end else begin
                                    state <= IDLE;
                                end
                            end
                        end
                    end
                    CHECK: begin
                        code_out    <= shreg;
                        crc_ok      <= (lfsr == 4'd0);
                        frame_valid <= 1'b1;
                        if (frame_cnt != {CNT_W{1'b1}}) begin
                            frame_cnt <= frame_cnt + 1'b1;
                        end
                        if (lfsr != 4'd0 && err_cnt != {CNT_W{1'b1}}) begin
                            err_cnt <= err_cnt + 1'b1;
                        end
                        state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_crc_frame_rx.sv
// Directed bench for crc_frame_rx: hand-computed codewords, latency, sync loss,
// reset/enable aborts and counter saturation.
module tb_crc_frame_rx;

    localparam int SP = 128;

    logic        clk_sys;
    logic        rst_n;
    logic        en;
    logic [7:0]  phase;
    logic [3:0]  sign_cnt;
    logic        in_bit;
    logic [15:0] code_out;
    logic [11:0] data_out;
    logic        crc_ok;
    logic        frame_valid;
    logic        sync_err;
    logic [7:0]  frame_cnt;
    logic [7:0]  err_cnt;
    logic [1:0]  state_dbg;

    int checks = 0;
    int errors = 0;
    int fv_count = 0;
    int se_count = 0;
    int fv_base;
    int se_base;

    crc_frame_rx #(.SAMPLE_PHASE(SP), .CNT_W(8)) dut (
        .clk_sys     (clk_sys),
        .rst_n       (rst_n),
        .en          (en),
        .phase       (phase),
        .sign_cnt    (sign_cnt),
        .in_bit      (in_bit),
        .code_out    (code_out),
        .data_out    (data_out),
        .crc_ok      (crc_ok),
        .frame_valid (frame_valid),
        .sync_err    (sync_err),
        .frame_cnt   (frame_cnt),
        .err_cnt     (err_cnt),
        .state_dbg   (state_dbg)
    );

    initial clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    always @(negedge clk_sys) begin
        if (frame_valid === 1'b1) fv_count++;
        if (sync_err === 1'b1) se_count++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive_sym(input logic [3:0] s, input logic b, input int p_lo, input int p_hi);
        for (int p = p_lo; p <= p_hi; p++) begin
            sign_cnt = s;
            phase    = p[7:0];
            in_bit   = b;
            @(posedge clk_sys);
            #1;
        end
    endtask

    // Returns 1 time unit after the edge that samples symbol 15.
    task automatic send_frame(input logic [15:0] code, input bit full);
        int lo;
        int hi;
        lo = full ? 0 : SP - 1;
        hi = full ? 255 : SP + 1;
        for (int s = 0; s < 15; s++) drive_sym(s[3:0], code[s], lo, hi);
        drive_sym(4'd15, code[15], lo, SP);
        phase = SP + 1;
    endtask

    task automatic check_frame(input string tag, input logic [15:0] code, input logic ok,
                               input logic [7:0] fc, input logic [7:0] ec);
        chk({tag, "_fv_early"}, frame_valid, 1'b0);
        @(posedge clk_sys);
        #1;
        chk({tag, "_fv"}, frame_valid, 1'b1);
        chk({tag, "_code"}, code_out, code);
        chk({tag, "_data"}, data_out, code[11:0]);
        chk({tag, "_crc_ok"}, crc_ok, ok);
        chk({tag, "_frame_cnt"}, frame_cnt, fc);
        chk({tag, "_err_cnt"}, err_cnt, ec);
        @(posedge clk_sys);
        #1;
        chk({tag, "_fv_drop"}, frame_valid, 1'b0);
    endtask

    initial begin
        rst_n    = 1'b0;
        en       = 1'b0;
        phase    = 8'd0;
        sign_cnt = 4'd0;
        in_bit   = 1'b0;
        repeat (3) @(posedge clk_sys);
        #1;
        chk("rst_code", code_out, 16'h0000);
        chk("rst_crc_ok", crc_ok, 1'b0);
        chk("rst_fv", frame_valid, 1'b0);
        chk("rst_se", sync_err, 1'b0);
        chk("rst_fc", frame_cnt, 8'd0);
        chk("rst_ec", err_cnt, 8'd0);
        chk("rst_state", state_dbg, 2'd0);
        @(negedge clk_sys);
        rst_n = 1'b1;
        en    = 1'b1;

        // 1: all-zero codeword over full 256-cycle symbols
        send_frame(16'h0000, 1'b1);
        check_frame("t1", 16'h0000, 1'b1, 8'd1, 8'd0);

        // 2: data 001 with CRC 0001 -> code 8001
        send_frame(16'h8001, 1'b0);
        check_frame("t2", 16'h8001, 1'b1, 8'd2, 8'd0);

        // 3: single-bit error
        send_frame(16'h8000, 1'b0);
        check_frame("t3", 16'h8000, 1'b0, 8'd3, 8'd1);

        // 4: enable arrives at symbol 7, tail of that frame must be ignored
        fv_base = fv_count;
        en = 1'b0;
        for (int s = 0; s < 7; s++) drive_sym(s[3:0], 1'b1, SP - 1, SP + 1);
        en = 1'b1;
        for (int s = 7; s < 16; s++) drive_sym(s[3:0], 1'b1, SP - 1, SP + 1);
        repeat (2) @(posedge clk_sys);
        #1;
        chk("t4_no_fv", fv_count - fv_base, 0);
        chk("t4_state", state_dbg, 2'd0);
        chk("t4_code_held", code_out, 16'h8000);
        chk("t4_fc_held", frame_cnt, 8'd3);
        send_frame(16'h8001, 1'b0);
        check_frame("t4", 16'h8001, 1'b1, 8'd4, 8'd1);

        // 5: sign_cnt jumps 5 -> 9
        fv_base = fv_count;
        se_base = se_count;
        for (int s = 0; s < 6; s++) drive_sym(s[3:0], 1'b0, SP - 1, SP + 1);
        drive_sym(4'd9, 1'b0, SP - 1, SP);
        phase = SP + 1;
        chk("t5_se", sync_err, 1'b1);
        chk("t5_ec", err_cnt, 8'd2);
        chk("t5_state", state_dbg, 2'd0);
        @(posedge clk_sys);
        #1;
        chk("t5_se_drop", sync_err, 1'b0);
        for (int s = 10; s < 16; s++) drive_sym(s[3:0], 1'b0, SP - 1, SP + 1);
        repeat (2) @(posedge clk_sys);
        #1;
        chk("t5_no_fv", fv_count - fv_base, 0);
        chk("t5_se_pulses", se_count - se_base, 1);
        // data 003 -> CRC 1000 -> code 1003
        send_frame(16'h1003, 1'b0);
        check_frame("t5", 16'h1003, 1'b1, 8'd5, 8'd2);

        // 5b: restart on sign_cnt==0 mid-frame
        se_base = se_count;
        for (int s = 0; s < 4; s++) drive_sym(s[3:0], 1'b1, SP - 1, SP + 1);
        send_frame(16'h1003, 1'b0);
        check_frame("t5b", 16'h1003, 1'b1, 8'd6, 8'd3);
        chk("t5b_se_pulses", se_count - se_base, 1);

        // 6: reset at bit 10
        for (int s = 0; s < 10; s++) drive_sym(s[3:0], s == 0, SP - 1, SP + 1);
        drive_sym(4'd10, 1'b0, SP - 1, SP);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_code", code_out, 16'h0000);
        chk("t6_rst_crc_ok", crc_ok, 1'b0);
        chk("t6_rst_fc", frame_cnt, 8'd0);
        chk("t6_rst_ec", err_cnt, 8'd0);
        chk("t6_rst_state", state_dbg, 2'd0);
        phase = SP + 1;
        @(negedge clk_sys);
        rst_n = 1'b1;
        @(posedge clk_sys);
        #1;

        // 6b: en drop mid-frame
        fv_base = fv_count;
        for (int s = 0; s < 8; s++) drive_sym(s[3:0], s == 0, SP - 1, SP + 1);
        chk("t6_recv", state_dbg, 2'd1);
        en = 1'b0;
        @(posedge clk_sys);
        #1;
        chk("t6_abort_state", state_dbg, 2'd0);
        en = 1'b1;
        for (int s = 8; s < 16; s++) drive_sym(s[3:0], s == 15, SP - 1, SP + 1);
        repeat (2) @(posedge clk_sys);
        #1;
        chk("t6_abort_no_fv", fv_count - fv_base, 0);
        chk("t6_abort_fc", frame_cnt, 8'd0);

        // 6c: 300 good frames, frame_cnt saturates
        fv_base = fv_count;
        for (int f = 0; f < 300; f++) begin
            send_frame(16'h8001, 1'b0);
            repeat (2) @(posedge clk_sys);
            #1;
            if (f == 254) chk("t6_fc_254", frame_cnt, 8'd255);
        end
        chk("t6_sat_fc", frame_cnt, 8'd255);
        chk("t6_sat_ec", err_cnt, 8'd0);
        chk("t6_sat_pulses", fv_count - fv_base, 300);
        chk("t6_sat_crc_ok", crc_ok, 1'b1);
        chk("t6_sat_code", code_out, 16'h8001);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
